// File: rtl/pwm_sample_modulator.sv
// PWM modulator: one sample word per 2**WIDTH-cycle period sets the number of high
// cycles. A one-entry holding register sits between the producer and the period boundary.
module pwm_sample_modulator #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] IDLE_DUTY = '0,
   parameter int unsigned      UF_WIDTH  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [WIDTH-1:0]    s_data,
   input  logic                s_valid,
   output logic                s_ready,
   output logic                pwm_out,
   output logic                period_tick,
   output logic [UF_WIDTH-1:0] underflow_cnt,
   input  logic                underflow_clr
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0]    r_cnt;
   logic [WIDTH-1:0]    r_duty;
   logic [WIDTH-1:0]    r_hold_data;
   logic                r_hold_full;
   logic                r_pwm;
   logic [UF_WIDTH-1:0] r_uf_cnt;

   logic w_accept;
   logic w_boundary;
   logic w_uf_sat;

   assign w_accept   = s_valid & ~r_hold_full;
   assign w_boundary = en & (r_cnt == CNT_MAX);
   assign w_uf_sat   = &r_uf_cnt;

   assign s_ready       = ~r_hold_full;
   assign pwm_out       = r_pwm;
   assign period_tick   = w_boundary;
   assign underflow_cnt = r_uf_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!en) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // The duty register changes only at a boundary, or when the modulator is disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_duty <= IDLE_DUTY;
      end else if (!en) begin
         r_duty <= IDLE_DUTY;
      end else if (w_boundary) begin
         r_duty <= r_hold_full ? r_hold_data : IDLE_DUTY;
      end
   end

   // A sample that arrives on a boundary cycle with an empty hold goes into the hold.
   // It is used in the period after the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_full <= 1'b0;
         r_hold_data <= '0;
      end else if (w_boundary && r_hold_full) begin
         r_hold_full <= 1'b0;
      end else if (w_accept) begin
         r_hold_full <= 1'b1;
         r_hold_data <= s_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm <= 1'b0;
      end else begin
         r_pwm <= en & (r_cnt < r_duty);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_uf_cnt <= '0;
      end else if (underflow_clr) begin
         r_uf_cnt <= '0;
      end else if (w_boundary && !r_hold_full && !w_uf_sat) begin
         r_uf_cnt <= r_uf_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pwm_sample_modulator.sv
// Directed bench for pwm_sample_modulator with WIDTH=4 (16-cycle period). A second
// instance with a 2-bit underflow counter shares the inputs and is used for saturation checks.
module tb_pwm_sample_modulator;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [3:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic        pwm_out;
   logic        period_tick;
   logic [15:0] uf;
   logic        underflow_clr;
   logic        s_ready2;
   logic        pwm2;
   logic        tick2;
   logic [1:0]  uf2;

   int n_vec = 0;
   int n_err = 0;

   logic [3:0] src_q[$];
   logic [3:0] exp_q[$];
   logic       feeding;

   pwm_sample_modulator #(.WIDTH(4), .IDLE_DUTY(4'd0), .UF_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .pwm_out(pwm_out), .period_tick(period_tick),
      .underflow_cnt(uf), .underflow_clr(underflow_clr)
   );

   pwm_sample_modulator #(.WIDTH(4), .IDLE_DUTY(4'd0), .UF_WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready2), .pwm_out(pwm2), .period_tick(tick2),
      .underflow_cnt(uf2), .underflow_clr(underflow_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive_src();
      if (feeding && src_q.size() > 0) begin
         s_valid = 1'b1;
         s_data  = src_q[0];
      end else begin
         s_valid = 1'b0;
         s_data  = 4'd0;
      end
   endtask

   // One clock: note whether the handshake fires at this edge, then step to #1 after the edge.
   task automatic tick();
      logic acc;
      acc = s_valid & s_ready;
      @(posedge clk);
      #1;
      if (acc) void'(src_q.pop_front());
      drive_src();
   endtask

   // Starts at cnt==0 and runs one full period, ending at cnt==0 of the next period.
   task automatic measure_period(input int exp_high, input int feed_step,
                                 input int exp_rdy1, input int exp_rdy16, input string tag);
      int hi;
      int tk;
      logic rdy1;
      hi = 0;
      tk = 0;
      rdy1 = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         hi += int'(pwm_out);
         tk += int'(period_tick);
         if (i == 1) rdy1 = s_ready;
         if (i == feed_step) begin
            feeding = 1'b1;
            drive_src();
         end
      end
      chk({tag, "_high"}, hi, exp_high);
      chk({tag, "_ticks"}, tk, 1);
      if (exp_rdy1 >= 0) chk({tag, "_rdy1"}, rdy1, exp_rdy1);
      if (exp_rdy16 >= 0) chk({tag, "_rdy16"}, s_ready, exp_rdy16);
   endtask

   initial begin
      int hi;
      int tk;
      rst_n = 1'b0;
      en = 1'b0;
      s_valid = 1'b0;
      s_data = 4'd0;
      underflow_clr = 1'b0;
      feeding = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_pwm", pwm_out, 0);
      chk("rst_rdy", s_ready, 1);
      chk("rst_uf", uf, 0);
      chk("rst_tick", period_tick, 0);
      rst_n = 1'b1;
      tick();
      tick();
      chk("idle_pwm", pwm_out, 0);
      chk("idle_tick", period_tick, 0);

      // Stream 5,12,0,15. The first sample is presented on the first boundary cycle.
      en = 1'b1;
      src_q = '{4'd5, 4'd12, 4'd0, 4'd15};
      measure_period(0, 15, -1, 0, "pA");
      measure_period(0, -1, 0, 1, "pB");
      measure_period(5, -1, 0, 1, "pC");
      measure_period(12, -1, 0, 1, "pD");
      measure_period(0, -1, 0, 1, "pE");
      chk("uf_after_stream", uf, 1);
      measure_period(15, -1, 1, 1, "pF");
      chk("uf_after_pF", uf, 2);

      // s_valid held high continuously; the scoreboard checks order and count.
      src_q = '{4'd3, 4'd9, 4'd14, 4'd1};
      exp_q = '{4'd3, 4'd9, 4'd14, 4'd1};
      drive_src();
      measure_period(0, -1, 0, 1, "pG");
      measure_period(int'(exp_q.pop_front()), -1, 0, 1, "pH");
      measure_period(int'(exp_q.pop_front()), -1, 0, 1, "pI");
      measure_period(int'(exp_q.pop_front()), -1, 0, 1, "pJ");
      measure_period(int'(exp_q.pop_front()), -1, 1, 1, "pK");
      chk("src_drained", src_q.size(), 0);
      chk("uf_after_pK", uf, 3);
      chk("uf2_after_pK", uf2, 3);

      // Sample 8 followed by starvation. Sample 6 is presented on a boundary cycle.
      src_q.push_back(4'd8);
      drive_src();
      measure_period(0, -1, 0, 1, "pL");
      measure_period(8, -1, 1, 1, "pM");
      chk("uf_after_pM", uf, 4);
      chk("uf2_sat_pM", uf2, 3);
      measure_period(0, -1, 1, 1, "pN");
      feeding = 1'b0;
      src_q.push_back(4'd6);
      drive_src();
      measure_period(0, 15, 1, 0, "pO");
      measure_period(0, -1, 0, 1, "pP");
      chk("uf_after_starve", uf, 6);
      chk("uf2_sat_pP", uf2, 3);
      measure_period(6, -1, 1, 1, "pQ");
      chk("uf_after_pQ", uf, 7);

      // Clear on a boundary cycle that would otherwise count an underflow.
      for (int i = 1; i <= 15; i++) tick();
      underflow_clr = 1'b1;
      tick();
      underflow_clr = 1'b0;
      chk("uf_clr", uf, 0);
      chk("uf2_clr", uf2, 0);

      // Drop en at cnt==7 with duty 10 while sample 13 is held.
      src_q = '{4'd10, 4'd13};
      drive_src();
      measure_period(0, -1, 0, 1, "pS");
      for (int i = 1; i <= 7; i++) tick();
      chk("en_pre_pwm", pwm_out, 1);
      en = 1'b0;
      tick();
      chk("en_drop_pwm", pwm_out, 0);
      chk("en_drop_tick", period_tick, 0);
      chk("en_drop_hold", s_ready, 0);
      hi = 0;
      tk = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         hi += int'(pwm_out);
         tk += int'(period_tick);
      end
      chk("en_off_high", hi, 0);
      chk("en_off_ticks", tk, 0);
      chk("en_off_uf", uf, 0);
      en = 1'b1;
      measure_period(0, -1, 0, 1, "pU");
      chk("uf_after_pU", uf, 0);
      measure_period(13, -1, 1, 1, "pV");
      chk("uf_after_pV", uf, 1);

      // Asynchronous reset mid-period while a sample is held.
      src_q = '{4'd9, 4'd4};
      drive_src();
      measure_period(0, -1, 0, 1, "pW");
      for (int i = 1; i <= 5; i++) tick();
      chk("pre_rst_pwm", pwm_out, 1);
      chk("pre_rst_rdy", s_ready, 0);
      chk("pre_rst_uf", uf, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_pwm", pwm_out, 0);
      chk("arst_rdy", s_ready, 1);
      chk("arst_uf", uf, 0);
      chk("arst_uf2", uf2, 0);
      chk("arst_tick", period_tick, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_src();
      measure_period(0, -1, 1, 1, "pY");
      chk("uf_hold_discarded", uf, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
